// File: rtl/riscv_ctrl_pkg.sv
//------------------------------------------------------------------------------
// riscv_ctrl_pkg : shared encodings for the multicycle RV32I controller
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUCTL_ADD = 3'b000;
    localparam logic [2:0] ALUCTL_SUB = 3'b001;
    localparam logic [2:0] ALUCTL_AND = 3'b010;
    localparam logic [2:0] ALUCTL_OR  = 3'b011;
    localparam logic [2:0] ALUCTL_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
//------------------------------------------------------------------------------
// alu_decoder : maps ALUOp and instruction function fields to ALUControl
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALUCTL_ADD;
        case (i_alu_op)
            ALUOP_SUB:   o_alu_control = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // Only R-type (op[5]=1) can encode sub; addi ignores funct7
                    3'b000:  o_alu_control = (i_op5 && i_funct7b5) ? ALUCTL_SUB : ALUCTL_ADD;
                    3'b010:  o_alu_control = ALUCTL_SLT;
                    3'b110:  o_alu_control = ALUCTL_OR;
                    3'b111:  o_alu_control = ALUCTL_AND;
                    default: o_alu_control = ALUCTL_ADD;
                endcase
            end
            default:     o_alu_control = ALUCTL_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// multicycle_control : Moore sequencing FSM for the multicycle RV32I datapath
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_done;
    logic       w_illegal;
    logic [1:0] w_alu_op;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = S_FETCH;
        AdrSrc      = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_done      = 1'b0;
        w_illegal   = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RD2;
        w_alu_op    = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_ir_write  = 1'b1;
                w_pc_update = 1'b1;
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURESULT;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECUTER;
                    OP_ITYPE:          w_next = S_EXECUTEI;
                    OP_JAL:            w_next = S_JAL;
                    OP_BRANCH:         w_next = S_BRANCH;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                        w_done    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
                w_done      = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA  = SRCA_RD1;
                w_alu_op = ALUOP_FUNCT;
                w_next   = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA  = SRCA_RD1;
                ALUSrcB  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            S_JAL: begin
                ALUSrcA     = SRCA_OLDPC;
                ALUSrcB     = SRCB_FOUR;
                w_pc_update = 1'b1;
                w_next      = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA  = SRCA_RD1;
                w_alu_op = ALUOP_SUB;
                w_branch = 1'b1;
                w_done   = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            default:   ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_op5         (op[5]),
        .i_funct7b5    (funct7b5),
        .o_alu_control (ALUControl)
    );

    // Enables are gated by reset directly so an abort never leaves a write pending
    assign PCWrite    = reset & (w_pc_update | (w_branch & (Zero ^ funct3[0])));
    assign MemWrite   = reset & w_mem_write;
    assign IRWrite    = reset & w_ir_write;
    assign RegWrite   = reset & w_reg_write;
    assign instr_done = reset & w_done;
    assign illegal    = reset & w_illegal;
    assign state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//------------------------------------------------------------------------------
// tb_multicycle_control : directed self-checking bench for multicycle_control
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state)
    );

    // Observed bundle: state,PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,done,illegal
    logic [21:0] w_obs;
    assign w_obs = {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                    ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done, illegal};

    function automatic logic [21:0] ex(input logic [3:0] st, input logic pcw, input logic adr,
                                       input logic mw, input logic irw, input logic rw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] imm,
                                       input logic [2:0] alc, input logic done, input logic ill);
        return {st, pcw, adr, mw, irw, rw, rs, sa, sb, imm, alc, done, ill};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d expected 0", state);
        end
        n_checks++;
        if ({PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal} !== 6'b0) begin
            n_fail++; $display("FAIL reset_enables: got %b expected 000000",
                               {PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal});
        end
        n_checks++;
        if (ALUSrcB !== 2'b10 || ResultSrc !== 2'b10) begin
            n_fail++; $display("FAIL reset_fetch_mux: got srcb=%b rs=%b expected 10/10", ALUSrcB, ResultSrc);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (w_obs !== ex(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0)) begin
            n_fail++; $display("FAIL first_fetch: got %h expected %h", w_obs,
                               ex(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0));
        end
    endtask

    task automatic test_load();
        logic [21:0] e [0:5];
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        e[0] = ex(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0);
        e[1] = ex(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 0);
        e[2] = ex(2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0);
        e[3] = ex(3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
        e[4] = ex(4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
        e[5] = ex(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0);
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) next_cycle();
            n_checks++;
            if (w_obs !== e[i]) begin
                n_fail++; $display("FAIL lw_step%0d: got %h expected %h", i, w_obs, e[i]);
            end
        end
    endtask

    task automatic test_store();
        logic [21:0] e [0:4];
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b1;
        e[0] = ex(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0);
        e[1] = ex(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0, 0);
        e[2] = ex(2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0, 0);
        e[3] = ex(5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1, 0);
        e[4] = ex(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            n_checks++;
            if (w_obs !== e[i]) begin
                n_fail++; $display("FAIL sw_step%0d: got %h expected %h", i, w_obs, e[i]);
            end
        end
    endtask

    // Each row: op, funct3, funct7b5, expected ALUControl in the execute state
    task automatic test_alu_ops();
        logic [6:0] t_op  [0:4] = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0010011};
        logic [2:0] t_f3  [0:4] = '{3'b000, 3'b111, 3'b000, 3'b110, 3'b010};
        logic       t_f7  [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0] t_alc [0:4] = '{3'b001, 3'b010, 3'b000, 3'b011, 3'b101};
        logic [21:0] e [0:3];
        for (int k = 0; k < 5; k++) begin
            op = t_op[k]; funct3 = t_f3[k]; funct7b5 = t_f7[k];
            e[0] = ex(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0);
            e[1] = ex(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 0);
            e[2] = (k < 2) ? ex(6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, t_alc[k], 0, 0)
                           : ex(8, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, t_alc[k], 0, 0);
            e[3] = ex(7, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (i > 0) next_cycle();
                n_checks++;
                if (w_obs !== e[i]) begin
                    n_fail++; $display("FAIL alu_case%0d_step%0d: got %h expected %h", k, i, w_obs, e[i]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_jal();
        logic [21:0] e [0:4];
        op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
        e[0] = ex(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 0, 0);
        e[1] = ex(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000, 0, 0);
        e[2] = ex(9, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0, 0);
        e[3] = ex(7, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1, 0);
        e[4] = ex(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 0, 0);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            n_checks++;
            if (w_obs !== e[i]) begin
                n_fail++; $display("FAIL jal_step%0d: got %h expected %h", i, w_obs, e[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0] t_f3  [0:3] = '{3'b000, 3'b000, 3'b001, 3'b001};
        logic       t_z   [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       t_pcw [0:3] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [21:0] e_br;
        op = 7'b1100011; funct7b5 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            funct3 = t_f3[k]; Zero = t_z[k];
            e_br = ex(10, t_pcw[k], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1, 0);
            #1;
            next_cycle();
            next_cycle();
            n_checks++;
            if (w_obs !== e_br) begin
                n_fail++; $display("FAIL branch_case%0d: got %h expected %h", k, w_obs, e_br);
            end
            next_cycle();
            n_checks++;
            if (state !== 4'd0) begin
                n_fail++; $display("FAIL branch_return%0d: got state %0d expected 0", k, state);
            end
        end
    endtask

    task automatic test_illegal();
        logic [21:0] e_dec;
        op = 7'b1111111; funct3 = 3'b000; Zero = 1'b0;
        e_dec = ex(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1, 1);
        #1;
        next_cycle();
        n_checks++;
        if (w_obs !== e_dec) begin
            n_fail++; $display("FAIL illegal_decode: got %h expected %h", w_obs, e_dec);
        end
        next_cycle();
        n_checks++;
        if (state !== 4'd0 || illegal !== 1'b0 || instr_done !== 1'b0) begin
            n_fail++; $display("FAIL illegal_return: got state=%0d ill=%b done=%b expected 0/0/0",
                               state, illegal, instr_done);
        end
    endtask

    task automatic test_reset_midinstr();
        op = 7'b0100011; funct3 = 3'b010;
        #1;
        repeat (3) next_cycle();
        n_checks++;
        if (state !== 4'd5 || MemWrite !== 1'b1) begin
            n_fail++; $display("FAIL abort_setup: got state=%0d mw=%b expected 5/1", state, MemWrite);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (MemWrite !== 1'b0 || state !== 4'd0 || instr_done !== 1'b0) begin
            n_fail++; $display("FAIL abort_async: got mw=%b state=%0d done=%b expected 0/0/0",
                               MemWrite, state, instr_done);
        end
        next_cycle();
        reset = 1'b1;
        next_cycle();
        n_checks++;
        if (state !== 4'd1) begin
            n_fail++; $display("FAIL abort_restart: got state %0d expected 1", state);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_alu_ops();
        test_jal();
        test_branch();
        test_illegal();
        test_reset_midinstr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Moore-style sequencing controller for the multicycle RV32I datapath. It steps the shared ALU, register file and unified instruction/data memory through fetch, decode, execute, memory and writeback. It drives every mux select and write enable from a state register. It sits beside `registers`/`ALU`/memory in the processor top and replaces single-cycle decode.

## Interface
Parameters:
- none (all encodings fixed in the shared package)

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `op`  in  7  instr[6:0], valid from DECODE onward
- `funct3`  in  3  instr[14:12]
- `funct7b5`  in  1  instr[30]
- `Zero`  in  1  ALU zero flag
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address: 0=PC, 1=ALUOut
- `MemWrite`  out  1  memory write enable
- `IRWrite`  out  1  instruction/OldPC register enable
- `RegWrite`  out  1  register-file write enable
- `ResultSrc`  out  2  00=ALUOut, 01=Data, 10=ALUResult
- `ALUSrcA`  out  2  00=PC, 01=OldPC, 10=A (RD1)
- `ALUSrcB`  out  2  00=WriteData (RD2), 01=ImmExt, 10=constant 4
- `ImmSrc`  out  2  00=I, 01=S, 10=B, 11=J
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `instr_done`  out  1  one-cycle pulse in the last state of each instruction
- `illegal`  out  1  one-cycle pulse on an unsupported opcode
- `state`  out  4  current state (debug/verification)

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BRANCH=10. Codes 11–15 go to FETCH.
- Each state's non-listed outputs are 0. ALUOp: 00 add, 01 sub, 10 funct-decoded.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next state DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes branch target). Next state depends on `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1101111 → JAL
  - 1100011 → BRANCH
  - any other opcode → FETCH, with `illegal`=1 and `instr_done`=1
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Next state MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, done. Next state FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, done. Next state FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, done. Next state FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state ALUWB.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, done. Next state FETCH.
- PCWrite = PCUpdate | (Branch & (Zero ^ funct3[0])). This gives beq (funct3=000) and bne (001).
- ALUControl from ALUOp:
  - 00 → add
  - 01 → sub
  - 10 → by funct3:
    - 000: sub if op[5]&funct7b5, else add
    - 010: slt
    - 110: or
    - 111: and
    - any other: add
- ImmSrc is combinational on `op`: 0100011→01, 1100011→10, 1101111→11, else 00.

## Timing
- The state register is the only sequential element. All outputs are combinational from `state`, `op`, `funct3`, `funct7b5` and `Zero`.
- While `reset`=0: state=FETCH; PCWrite, IRWrite, MemWrite, RegWrite, `instr_done` and `illegal` are forced to 0; other outputs show FETCH values.
- The first real FETCH is the cycle after `reset` deasserts. Reset asserted mid-instruction aborts it immediately; no write enable glitches high.
- Latency in cycles, FETCH to done inclusive:
  - lw 5
  - sw 4
  - R-type 4
  - I-type 4
  - jal 4
  - branch 3
  - illegal 2
- `op`/funct fields are sampled only from DECODE onward. The IR is stable because IRWrite is 1 only in FETCH.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - state codes
  - opcode constants
  - ALUOp and ALUControl codes
  - ResultSrc/ALUSrcA/ALUSrcB/ImmSrc encodings
- Sub-module `alu_decoder` maps (ALUOp, funct3, op[5], funct7b5) to ALUControl, and is purely combinational.
- The main FSM and output logic live in `multicycle_control`.

## Test plan
- Reset held low for 3 cycles, then released → state=0, all enables 0 during reset; cycle 1 after release shows IRWrite=1, PCWrite=1, ALUSrcB=10.
- op=0000011 (lw) → states 0,1,2,3,4; RegWrite=1 only in state 4 with ResultSrc=01; `instr_done` pulses exactly once.
- op=0100011 (sw) → states 0,1,2,5; MemWrite=1 only in state 5 with AdrSrc=1; ImmSrc=01 throughout.
- op=0110011, funct3=000, funct7b5=1 → ALUControl=001 in EXECUTER; with funct3=111 → 010; RegWrite in ALUWB.
- op=1100011: funct3=000 with Zero=1 → PCWrite=1 in BRANCH; funct3=000 with Zero=0 → PCWrite=0; funct3=001 with Zero=0 → PCWrite=1.
- op=1111111 → `illegal` and `instr_done` pulse in DECODE, no write enables asserted, next state FETCH. Reset asserted in MEMWRITE → MemWrite drops to 0 asynchronously.
